// File: rtl/pwm_decode_pkg.sv
// rtl/pwm_decode_pkg.sv - shared state type and arithmetic helpers for the PWM pair decoder
package pwm_decode_pkg;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    // Mid-scale high count: a PWM at 50% duty reports zero.
    function automatic int mid_of(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

    function automatic int sat(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// rtl/pwm_sync_edge.sv - multi-flop synchronizer with delayed copy for rise/fall detection
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic sig_s,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   sig_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            sig_d <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig};
            sig_d <= sync[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;
    assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/pwm_decode.sv
// rtl/pwm_decode.sv - PWM1/PWM2 receive decoder: period, signed duty, overlap and stuck detection
module pwm_decode
    import pwm_decode_pkg::*;
#(
    parameter int CNT_W       = 11,
    parameter int TIMEOUT     = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PWM1,
    input  logic                  PWM2,
    output logic signed [CNT_W:0] duty,
    output logic [CNT_W:0]        period,
    output logic                  vld,
    output logic                  stuck,
    output logic                  ovlp_err
);
    localparam int MID  = mid_of(CNT_W);
    localparam int PMAX = (1 << (CNT_W + 1)) - 1;
    localparam int TW   = $clog2(TIMEOUT + 1);
    // Counters must be able to reach TIMEOUT even when it exceeds the reported period range.
    localparam int CW   = (TW > CNT_W + 1) ? TW : CNT_W + 1;

    logic          p1_s;
    logic          p1_rise;
    logic          p1_fall;
    logic          p2_s;
    logic          unused_p2_rise;
    logic          unused_p2_fall;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] per_cnt;
    logic [CW-1:0] hi_cnt;
    logic          capture;
    logic          enter_stuck;
    logic          restart;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (PWM1),
        .sig_s (p1_s),
        .rise  (p1_rise),
        .fall  (p1_fall)
    );

    pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_p2 (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (PWM2),
        .sig_s (p2_s),
        .rise  (unused_p2_rise),
        .fall  (unused_p2_fall)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A rise always takes priority over the timeout in the same clock.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        enter_stuck = 1'b0;
        restart     = 1'b0;
        case (state_q)
            IDLE: begin
                if (p1_rise) begin
                    restart = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH, LOW: begin
                if (p1_rise) begin
                    capture = 1'b1;
                    restart = 1'b1;
                    state_d = HIGH;
                end else if (per_cnt >= CW'(TIMEOUT)) begin
                    enter_stuck = 1'b1;
                    state_d     = STUCK;
                end else if (state_q == HIGH && p1_fall) begin
                    state_d = LOW;
                end
            end
            STUCK: begin
                if (p1_rise) begin
                    restart = 1'b1;
                    state_d = HIGH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (restart) begin
            per_cnt <= CW'(1);
            hi_cnt  <= CW'(1);
        end else if (state_q != IDLE) begin
            per_cnt <= sat_inc(per_cnt);
            if (p1_s) hi_cnt <= sat_inc(hi_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty     <= '0;
            period   <= '0;
            vld      <= 1'b0;
            stuck    <= 1'b0;
            ovlp_err <= 1'b0;
        end else begin
            vld      <= capture | enter_stuck;
            ovlp_err <= p1_s & p2_s;
            if (capture) begin
                duty   <= (CNT_W + 1)'(sat(int'(hi_cnt) - MID, -MID, MID - 1));
                period <= (CNT_W + 1)'(sat(int'(per_cnt), 0, PMAX));
            end else if (enter_stuck) begin
                duty   <= p1_s ? (CNT_W + 1)'(MID - 1) : (CNT_W + 1)'(-MID);
                period <= '1;
            end
            if (enter_stuck)  stuck <= 1'b1;
            else if (restart) stuck <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_decode.sv
// tb/tb_pwm_decode.sv - self-checking bench for pwm_decode against a cycle-level PWM reference model
module tb_pwm_decode;
    localparam int CNT_W   = 11;
    localparam int TIMEOUT = 4096;
    localparam int MID     = 1024;
    localparam int PMAX    = 4095;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  PWM1  = 1'b0;
    logic                  PWM2  = 1'b0;
    logic signed [CNT_W:0] duty;
    logic [CNT_W:0]        period;
    logic                  vld;
    logic                  stuck;
    logic                  ovlp_err;

    typedef struct {
        int duty;
        int period;
        bit stuck;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];
    int  cyc      = 0;
    int  ovlp_cnt = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  lat      = -1;
    bit  m_run    = 1'b0;
    bit  m_prev   = 1'b0;
    int  m_last   = 0;
    int  m_hi     = 0;

    pwm_decode #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PWM1     (PWM1),
        .PWM2     (PWM2),
        .duty     (duty),
        .period   (period),
        .vld      (vld),
        .stuck    (stuck),
        .ovlp_err (ovlp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (vld) got_q.push_back('{int'(duty), int'(period), stuck, cyc});
        if (ovlp_err) ovlp_cnt = ovlp_cnt + 1;
    end

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference: a report is due at every pin rise once running, or TIMEOUT clocks after the last rise.
    task automatic model_step(input int c, input bit p);
        if (p && !m_prev) begin
            if (m_run)
                exp_q.push_back('{clamp(m_hi - MID, -MID, MID - 1), clamp(c - m_last, 0, PMAX), 1'b0, c});
            m_run  = 1'b1;
            m_last = c;
            m_hi   = 0;
        end else if (m_run && (c - m_last) == TIMEOUT) begin
            exp_q.push_back('{p ? MID - 1 : -MID, PMAX, 1'b1, c});
            m_run = 1'b0;
        end
        if (p) m_hi = m_hi + 1;
        m_prev = p;
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_prev = 1'b0;
        m_hi   = 0;
    endtask

    task automatic step(input bit p1, input bit p2);
        PWM1 = p1;
        PWM2 = p2;
        model_step(cyc, p1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b1);
    endtask

    task automatic pwm_period(input int hi, input int per, input int ov_at);
        bit p1;
        bit p2;
        for (int k = 0; k < per; k++) begin
            p1 = (k < hi);
            p2 = !p1 && (k >= hi + 2) && (k < per - 2);
            if (ov_at >= 0 && k >= ov_at && k < ov_at + 3) p2 = 1'b1;
            step(p1, p2);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        PWM1  = 1'b0;
        PWM2  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (duty !== 0 || period !== 0) begin
            n_fail++;
            $display("FAIL reset_values: duty=%0d period=%0d, required 0 0", duty, period);
        end
        n_checks++;
        if (vld !== 1'b0 || stuck !== 1'b0 || ovlp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: vld=%b stuck=%b ovlp_err=%b, required 0 0 0", vld, stuck, ovlp_err);
        end
        rst_n = 1'b1;
        model_reset();
        idle(20);
        n_checks++;
        if (got_q.size() != 0 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: vld_count=%0d stuck=%b, required 0 0", got_q.size(), stuck);
        end
    endtask

    task automatic test_nominal();
        ev_t e;
        ev_t g;
        int  ov0;
        int  per;
        ov0 = ovlp_cnt;
        repeat (5) pwm_period(1024, 2048, -1);
        pwm_period(1791, 2048, -1);
        pwm_period(256, 2048, -1);
        repeat (4) begin
            per = $urandom_range(600, 3000);
            pwm_period($urandom_range(1, per - 1), per, -1);
        end
        idle(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL nominal_vld: no vld, required duty=%0d period=%0d", e.duty, e.period);
            end else begin
                g = got_q.pop_front();
                if (lat < 0) lat = g.cyc - e.cyc;
                if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                    n_fail++;
                    $display("FAIL nominal_vld: got duty=%0d period=%0d stuck=%0d lat=%0d, required duty=%0d period=%0d stuck=%0d lat=%0d",
                             g.duty, g.period, g.stuck, g.cyc - e.cyc, e.duty, e.period, e.stuck, lat);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_extra_vld: %0d extra pulses, required 0", got_q.size());
            got_q.delete();
        end
        n_checks++;
        if (ovlp_cnt - ov0 !== 0) begin
            n_fail++;
            $display("FAIL nominal_dead_time: ovlp pulses=%0d, required 0", ovlp_cnt - ov0);
        end
    endtask

    task automatic test_overlap();
        ev_t e;
        ev_t g;
        int  ov0;
        ov0 = ovlp_cnt;
        pwm_period(1024, 2048, 500);
        pwm_period(1024, 2048, -1);
        idle(10);
        n_checks++;
        if (ovlp_cnt - ov0 !== 3) begin
            n_fail++;
            $display("FAIL overlap_pulses: got %0d, required 3", ovlp_cnt - ov0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL overlap_vld: no vld, required duty=%0d period=%0d", e.duty, e.period);
            end else begin
                g = got_q.pop_front();
                if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                    n_fail++;
                    $display("FAIL overlap_vld: got duty=%0d period=%0d stuck=%0d lat=%0d, required duty=%0d period=%0d stuck=%0d lat=%0d",
                             g.duty, g.period, g.stuck, g.cyc - e.cyc, e.duty, e.period, e.stuck, lat);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL overlap_extra_vld: %0d extra pulses, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_stuck();
        ev_t e;
        ev_t g;
        pwm_period(500, TIMEOUT + 300, -1);
        n_checks++;
        if (stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_low_level: stuck=%b, required 1", stuck);
        end
        pwm_period(1024, 2048, -1);
        n_checks++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_cleared: stuck=%b, required 0", stuck);
        end
        pwm_period(TIMEOUT + 104, TIMEOUT + 204, -1);
        idle(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL stuck_vld: no vld, required duty=%0d period=%0d", e.duty, e.period);
            end else begin
                g = got_q.pop_front();
                if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                    n_fail++;
                    $display("FAIL stuck_vld: got duty=%0d period=%0d stuck=%0d lat=%0d, required duty=%0d period=%0d stuck=%0d lat=%0d",
                             g.duty, g.period, g.stuck, g.cyc - e.cyc, e.duty, e.period, e.stuck, lat);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL stuck_extra_vld: %0d extra pulses, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_exact_timeout();
        ev_t e;
        ev_t g;
        pwm_period(100, 2048, -1);
        pwm_period(100, TIMEOUT, -1);
        pwm_period(300, TIMEOUT + 1, -1);
        pwm_period(200, 2048, -1);
        pwm_period(100, 2048, -1);
        idle(10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL exact_vld: no vld, required duty=%0d period=%0d", e.duty, e.period);
            end else begin
                g = got_q.pop_front();
                if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                    n_fail++;
                    $display("FAIL exact_vld: got duty=%0d period=%0d stuck=%0d lat=%0d, required duty=%0d period=%0d stuck=%0d lat=%0d",
                             g.duty, g.period, g.stuck, g.cyc - e.cyc, e.duty, e.period, e.stuck, lat);
                end
            end
        end
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL exact_extra_vld: %0d extra pulses, required 0", got_q.size());
            got_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        ev_t e;
        ev_t g;
        pwm_period(1024, 2048, -1);
        repeat (500) step(1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL pre_reset_vld: no vld, required duty=%0d period=%0d", e.duty, e.period);
            end else begin
                g = got_q.pop_front();
                if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                    n_fail++;
                    $display("FAIL pre_reset_vld: got duty=%0d period=%0d lat=%0d, required duty=%0d period=%0d lat=%0d",
                             g.duty, g.period, g.cyc - e.cyc, e.duty, e.period, lat);
                end
            end
        end
        rst_n = 1'b0;
        PWM1  = 1'b0;
        PWM2  = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (duty !== 0 || period !== 0 || vld !== 1'b0 || stuck !== 1'b0 || ovlp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: duty=%0d period=%0d vld=%b stuck=%b ovlp=%b, required all 0",
                     duty, period, vld, stuck, ovlp_err);
        end
        rst_n = 1'b1;
        model_reset();
        pwm_period(1024, 2048, -1);
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++;
            $display("FAIL first_rise_after_reset: %0d vld pulses, required 0", got_q.size());
            got_q.delete();
        end
        pwm_period(700, 2048, -1);
        idle(10);
        n_checks++;
        if (exp_q.size() != 1 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL second_rise_after_reset: got %0d vld, model %0d, required 1", got_q.size(), exp_q.size());
        end else begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g.duty !== e.duty || g.period !== e.period || g.stuck !== e.stuck || g.cyc - e.cyc !== lat) begin
                n_fail++;
                $display("FAIL post_reset_vld: got duty=%0d period=%0d lat=%0d, required duty=%0d period=%0d lat=%0d",
                         g.duty, g.period, g.cyc - e.cyc, e.duty, e.period, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overlap();
        test_stuck();
        test_exact_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
